// File: rtl/max_pool_seq.sv
// -----------------------------------------------------------------------------
// max_pool_seq
//
// Sequential 2x2 / stride-2 max-pooling stage. Walks every feature map, output
// row and output column with counters and writes one pooled binary16 element
// per clock into the registered output bus. Odd input heights/widths drop the
// last row/column.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (0 = reset asserted)
//   start      begin a pooling pass; sampled when idle (and on the done cycle)
//   inputMaps  D*H*W elements, element e at [e*DATA_WIDTH +: DATA_WIDTH],
//              e = k*H*W + y*W + x
//   outputPool D*(H/2)*(W/2) pooled elements, same ordering, registered
//   busy       high while a pass is running
//   done       one-cycle pulse after the final element is written
// -----------------------------------------------------------------------------
module max_pool_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 6,
    parameter int H          = 28,
    parameter int W          = 28
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     start,
    input  logic [0:D*H*W*DATA_WIDTH-1]              inputMaps,
    output logic [0:D*(H/2)*(W/2)*DATA_WIDTH-1]      outputPool,
    output logic                                     busy,
    output logic                                     done
);

    localparam int HO       = H / 2;
    localparam int WO       = W / 2;
    localparam int N        = D * HO * WO;
    localparam int IN_ELEMS = D * H * W;
    localparam int IN_BITS  = IN_ELEMS * DATA_WIDTH;
    localparam int KW       = (D  > 1) ? $clog2(D)  : 1;
    localparam int RW       = (HO > 1) ? $clog2(HO) : 1;
    localparam int CW       = (WO > 1) ? $clog2(WO) : 1;
    localparam int NW       = (N  > 1) ? $clog2(N)  : 1;
    // Element index width: must hold the largest row/map stride constant too.
    localparam int IW       = $clog2(IN_ELEMS + 1);
    // Bit offset width matches the input bus index range exactly.
    localparam int OW       = $clog2(IN_BITS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [KW-1:0]   k_q;
    logic [RW-1:0]   r_q;
    logic [CW-1:0]   c_q;
    logic [NW-1:0]   n_q;
    logic            busy_q;
    logic            done_q;

    // Sign-magnitude "strictly greater" for binary16-style encodings.
    // Both magnitudes zero (+0 / -0) count as equal so the earlier operand wins.
    function automatic logic gt(input logic [DATA_WIDTH-1:0] a,
                                input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-2:0] ma;
        logic [DATA_WIDTH-2:0] mb;
        ma = a[DATA_WIDTH-2:0];
        mb = b[DATA_WIDTH-2:0];
        if (ma == '0 && mb == '0) begin
            return 1'b0;
        end else if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) begin
            return ~a[DATA_WIDTH-1];
        end else if (!a[DATA_WIDTH-1]) begin
            return ma > mb;
        end else begin
            return ma < mb;
        end
    endfunction

    // Element index of the top-left tap of the current window.
    logic [IW-1:0] base_idx;
    assign base_idx = IW'(k_q) * IW'(H * W)
                    + IW'(r_q) * IW'(2 * W)
                    + IW'(c_q) * IW'(2);

    // Window taps in order (0,0),(0,1),(1,0),(1,1).
    logic [3:0][DATA_WIDTH-1:0] tap;

    for (genvar gi = 0; gi < 4; gi++) begin : g_tap
        localparam int TAP_OFS = (gi / 2) * W + (gi % 2);
        logic [IW-1:0] tap_idx;
        logic [OW-1:0] tap_off;
        assign tap_idx = base_idx + IW'(TAP_OFS);
        assign tap_off = OW'(tap_idx) * OW'(DATA_WIDTH);
        assign tap[gi] = inputMaps[tap_off +: DATA_WIDTH];
    end

    // Two pairwise compares then a final one; ties keep the earlier operand,
    // so the later operand only replaces on a strict win.
    logic [DATA_WIDTH-1:0] max_top;
    logic [DATA_WIDTH-1:0] max_bot;
    logic [DATA_WIDTH-1:0] pooled_d;
    assign max_top  = gt(tap[1], tap[0]) ? tap[1] : tap[0];
    assign max_bot  = gt(tap[3], tap[2]) ? tap[3] : tap[2];
    assign pooled_d = gt(max_bot, max_top) ? max_bot : max_top;

    // One register per output slot; only the slot addressed by n_q loads.
    // Unwritten slots keep their previous-pass contents.
    for (genvar gi = 0; gi < N; gi++) begin : g_slot
        logic [DATA_WIDTH-1:0] slot_q;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                slot_q <= '0;
            end else if (state_q == S_RUN && n_q == NW'(gi)) begin
                slot_q <= pooled_d;
            end
        end
        assign outputPool[gi*DATA_WIDTH +: DATA_WIDTH] = slot_q;
    end

    // Control FSM with registered busy/done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            n_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        k_q     <= '0;
                        r_q     <= '0;
                        c_q     <= '0;
                        n_q     <= '0;
                    end
                end
                S_RUN: begin
                    if (n_q == NW'(N - 1)) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        k_q     <= '0;
                        r_q     <= '0;
                        c_q     <= '0;
                        n_q     <= '0;
                    end else begin
                        n_q <= n_q + NW'(1);
                        if (c_q == CW'(WO - 1)) begin
                            c_q <= '0;
                            if (r_q == RW'(HO - 1)) begin
                                r_q <= '0;
                                k_q <= k_q + KW'(1);
                            end else begin
                                r_q <= r_q + RW'(1);
                            end
                        end else begin
                            c_q <= c_q + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    // The done cycle doubles as the return to idle: a start
                    // seen here launches the next pass immediately, giving
                    // back-to-back passes with a single done cycle between.
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_max_pool_seq.sv
// -----------------------------------------------------------------------------
// tb_max_pool_seq
//
// Three instances of max_pool_seq (1x4x4, 6x28x28, 2x5x5) share one clock.
// A behavioural model predicts busy/done/outputPool per cycle using a signed
// integer key per binary16 value (+0 and -0 map to the same key), and one
// process compares every instance against it on each falling edge. Directed
// passes add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_max_pool_seq;

    localparam int DW  = 16;
    localparam int D0  = 1, H0 = 4,  W0 = 4;
    localparam int D1  = 6, H1 = 28, W1 = 28;
    localparam int D2  = 2, H2 = 5,  W2 = 5;
    localparam int NI0 = D0*H0*W0, NO0 = D0*(H0/2)*(W0/2);
    localparam int NI1 = D1*H1*W1, NO1 = D1*(H1/2)*(W1/2);
    localparam int NI2 = D2*H2*W2, NO2 = D2*(H2/2)*(W2/2);
    localparam int MAXI = NI1;
    localparam int MAXO = NO1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, rst2;
    logic st0, st1, st2;
    logic busy0, busy1, busy2;
    logic done0, done1, done2;
    logic [0:NI0*DW-1] maps0;
    logic [0:NI1*DW-1] maps1;
    logic [0:NI2*DW-1] maps2;
    logic [0:NO0*DW-1] pool0;
    logic [0:NO1*DW-1] pool1;
    logic [0:NO2*DW-1] pool2;

    logic [15:0] in_m [3][MAXI];
    logic [15:0] act0 [NO0];
    logic [15:0] act1 [NO1];
    logic [15:0] act2 [NO2];

    int checks   = 0;
    int failures = 0;

    always_comb begin
        maps0 = '0;
        for (int e = 0; e < NI0; e++) maps0[e*DW +: DW] = in_m[0][e];
    end
    always_comb begin
        maps1 = '0;
        for (int e = 0; e < NI1; e++) maps1[e*DW +: DW] = in_m[1][e];
    end
    always_comb begin
        maps2 = '0;
        for (int e = 0; e < NI2; e++) maps2[e*DW +: DW] = in_m[2][e];
    end
    always_comb for (int e = 0; e < NO0; e++) act0[e] = pool0[e*DW +: DW];
    always_comb for (int e = 0; e < NO1; e++) act1[e] = pool1[e*DW +: DW];
    always_comb for (int e = 0; e < NO2; e++) act2[e] = pool2[e*DW +: DW];

    max_pool_seq #(.DATA_WIDTH(DW), .D(D0), .H(H0), .W(W0)) u_small (
        .clk(clk), .reset(rst0), .start(st0), .inputMaps(maps0),
        .outputPool(pool0), .busy(busy0), .done(done0));
    max_pool_seq #(.DATA_WIDTH(DW), .D(D1), .H(H1), .W(W1)) u_dflt (
        .clk(clk), .reset(rst1), .start(st1), .inputMaps(maps1),
        .outputPool(pool1), .busy(busy1), .done(done1));
    max_pool_seq #(.DATA_WIDTH(DW), .D(D2), .H(H2), .W(W2)) u_odd (
        .clk(clk), .reset(rst2), .start(st2), .inputMaps(maps2),
        .outputPool(pool2), .busy(busy2), .done(done2));

    // ---------------- per-instance accessors ----------------
    function automatic int cfg_d(int i);
        case (i) 0: return D0; 1: return D1; default: return D2; endcase
    endfunction
    function automatic int cfg_h(int i);
        case (i) 0: return H0; 1: return H1; default: return H2; endcase
    endfunction
    function automatic int cfg_w(int i);
        case (i) 0: return W0; 1: return W1; default: return W2; endcase
    endfunction
    function automatic int cfg_no(int i);
        return cfg_d(i) * (cfg_h(i) / 2) * (cfg_w(i) / 2);
    endfunction
    function automatic logic get_rst(int i);
        case (i) 0: return rst0; 1: return rst1; default: return rst2; endcase
    endfunction
    function automatic logic get_start(int i);
        case (i) 0: return st0; 1: return st1; default: return st2; endcase
    endfunction
    function automatic logic get_busy(int i);
        case (i) 0: return busy0; 1: return busy1; default: return busy2; endcase
    endfunction
    function automatic logic get_done(int i);
        case (i) 0: return done0; 1: return done1; default: return done2; endcase
    endfunction
    function automatic logic [15:0] get_act(int i, int e);
        case (i) 0: return act0[e]; 1: return act1[e]; default: return act2[e]; endcase
    endfunction

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 running, 2 done cycle
    int          phase [3];
    int          nidx  [3];
    logic [15:0] exp_pool [3][MAXO];

    // Ordering key: sign-magnitude value as a signed integer.
    function automatic int key16(logic [15:0] v);
        int m;
        m = int'(v[14:0]);
        return v[15] ? -m : m;
    endfunction

    function automatic logic [15:0] window_max(int i, int n);
        int h, w, ho, wo, k, rem, r, c;
        logic [15:0] best, cand;
        h = cfg_h(i); w = cfg_w(i); ho = h / 2; wo = w / 2;
        k = n / (ho * wo); rem = n % (ho * wo); r = rem / wo; c = rem % wo;
        best = in_m[i][k*h*w + (2*r)*w + 2*c];
        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++) begin
                cand = in_m[i][k*h*w + (2*r+a)*w + 2*c + b];
                if (key16(cand) > key16(best)) best = cand;
            end
        return best;
    endfunction

    task automatic model_clear(int i);
        phase[i] = 0;
        nidx[i]  = 0;
        for (int e = 0; e < MAXO; e++) exp_pool[i][e] = 16'h0000;
    endtask

    task automatic model_edge(int i);
        if (!get_rst(i)) begin
            model_clear(i);
        end else begin
            case (phase[i])
                0: if (get_start(i)) begin phase[i] = 1; nidx[i] = 0; end
                1: begin
                    exp_pool[i][nidx[i]] = window_max(i, nidx[i]);
                    nidx[i]++;
                    if (nidx[i] == cfg_no(i)) phase[i] = 2;
                end
                default: if (get_start(i)) begin phase[i] = 1; nidx[i] = 0; end
                         else phase[i] = 0;
            endcase
        end
    endtask

    task automatic compare_inst(int i);
        int bad;
        checks++;
        if (get_busy(i) !== (phase[i] == 1)) begin
            failures++;
            $display("FAIL busy[%0d] t=%0t got %b expected %b", i, $time, get_busy(i), phase[i] == 1);
        end
        checks++;
        if (get_done(i) !== (phase[i] == 2)) begin
            failures++;
            $display("FAIL done[%0d] t=%0t got %b expected %b", i, $time, get_done(i), phase[i] == 2);
        end
        bad = -1;
        for (int e = 0; e < cfg_no(i); e++)
            if (get_act(i, e) !== exp_pool[i][e]) begin bad = e; break; end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL pool[%0d][%0d] t=%0t got %h expected %h", i, bad, $time,
                     get_act(i, bad), exp_pool[i][bad]);
        end
    endtask

    // Model steps on each rising edge; reset is level-checked again on the
    // falling edge so an asynchronous assertion is reflected before comparing.
    initial begin
        for (int i = 0; i < 3; i++) model_clear(i);
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) model_edge(i);
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!get_rst(i)) model_clear(i);
                compare_inst(i);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_val(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end else begin
            $display("check %s = %0h ok", name, act);
        end
    endtask

    task automatic set_start(int i, logic v);
        case (i) 0: st0 = v; 1: st1 = v; default: st2 = v; endcase
    endtask
    task automatic set_rst(int i, logic v);
        case (i) 0: rst0 = v; 1: rst1 = v; default: rst2 = v; endcase
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int nonzero_count(int i);
        int cnt;
        cnt = 0;
        for (int e = 0; e < cfg_no(i); e++) if (get_act(i, e) != 16'h0000) cnt++;
        return cnt;
    endfunction

    // Pulse start and count edges from the start edge (inclusive) to done.
    // With spam set, extra start pulses are injected while busy.
    task automatic run_pass(int i, int limit, int spam, output int edges, output int busy_cycles);
        edges = 0;
        busy_cycles = 0;
        set_start(i, 1'b1);
        do begin
            tick();
            edges++;
            if (spam != 0 && edges % 200 == 0) set_start(i, 1'b1);
            else set_start(i, 1'b0);
            if (get_busy(i)) busy_cycles++;
        end while (!get_done(i) && edges < limit);
        $display("pass inst=%0d edges=%0d busy_cycles=%0d", i, edges, busy_cycles);
    endtask

    logic [15:0] ramp_v [16];
    logic [15:0] sign_v [16];
    logic [15:0] ramp_exp [4];
    logic [15:0] sign_exp [4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int edges, busyc, extra;
        int dq[$];

        ramp_v   = '{16'h0000, 16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700,
                     16'h4800, 16'h4880, 16'h4900, 16'h4980, 16'h4A00, 16'h4A80, 16'h4B00, 16'h4B80};
        ramp_exp = '{16'h4500, 16'h4700, 16'h4A80, 16'h4B80};
        sign_v   = '{16'hBC00, 16'hC000, 16'h0000, 16'h8000, 16'h8000, 16'hC200, 16'hBC00, 16'hC000,
                     16'hBC00, 16'hC000, 16'h8000, 16'h0000, 16'hC200, 16'hC400, 16'hBC00, 16'h8000};
        sign_exp = '{16'h8000, 16'h0000, 16'hBC00, 16'h8000};

        // Reset asserted with random maps and start high.
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        st0 = 1'b1; st1 = 1'b1; st2 = 1'b1;
        for (int i = 0; i < 3; i++)
            for (int e = 0; e < MAXI; e++) in_m[i][e] = 16'($urandom);
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("reset_busy%0d", i), 32'(get_busy(i)), 32'd0);
            check_val($sformatf("reset_done%0d", i), 32'(get_done(i)), 32'd0);
            check_val($sformatf("reset_pool_nz%0d", i), 32'(nonzero_count(i)), 32'd0);
        end
        st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 3; i++)
            check_val($sformatf("idle_busy%0d", i), 32'(get_busy(i)), 32'd0);

        // Ramp on 1x4x4.
        for (int e = 0; e < 16; e++) in_m[0][e] = ramp_v[e];
        run_pass(0, 50, 0, edges, busyc);
        check_val("ramp_latency", 32'(edges), 32'd5);
        check_val("ramp_busy_cycles", 32'(busyc), 32'd4);
        for (int e = 0; e < 4; e++) begin
            check_val($sformatf("ramp_out%0d", e), 32'(act0[e]), 32'(ramp_exp[e]));
            check_val($sformatf("ramp_model%0d", e), 32'(exp_pool[0][e]), 32'(ramp_exp[e]));
        end
        repeat (2) tick();

        // Sign-magnitude ordering and tie handling.
        for (int e = 0; e < 16; e++) in_m[0][e] = sign_v[e];
        run_pass(0, 50, 0, edges, busyc);
        check_val("sign_latency", 32'(edges), 32'd5);
        for (int e = 0; e < 4; e++) begin
            check_val($sformatf("sign_out%0d", e), 32'(act0[e]), 32'(sign_exp[e]));
            check_val($sformatf("sign_model%0d", e), 32'(exp_pool[0][e]), 32'(sign_exp[e]));
        end
        repeat (2) tick();

        // Default geometry, random maps, start pulses while busy.
        for (int e = 0; e < NI1; e++) in_m[1][e] = 16'($urandom);
        run_pass(1, 2000, 1, edges, busyc);
        check_val("dflt_latency", 32'(edges), 32'd1177);
        check_val("dflt_busy_cycles", 32'(busyc), 32'd1176);
        extra = 0;
        repeat (4) begin
            tick();
            if (done1) extra++;
        end
        check_val("dflt_extra_done", 32'(extra), 32'd0);
        check_val("dflt_idle_busy", 32'(busy1), 32'd0);

        // Mid-run reset after 500 cycles of RUN.
        for (int e = 0; e < NI1; e++) in_m[1][e] = 16'($urandom);
        set_start(1, 1'b1);
        tick();
        set_start(1, 1'b0);
        repeat (500) tick();
        check_val("midrun_busy_before", 32'(busy1), 32'd1);
        set_rst(1, 1'b0);
        #2;
        check_val("midrun_busy", 32'(busy1), 32'd0);
        check_val("midrun_done", 32'(done1), 32'd0);
        check_val("midrun_pool_nz", 32'(nonzero_count(1)), 32'd0);
        repeat (2) tick();
        set_rst(1, 1'b1);
        tick();
        check_val("midrun_idle_busy", 32'(busy1), 32'd0);
        run_pass(1, 2000, 0, edges, busyc);
        check_val("postreset_latency", 32'(edges), 32'd1177);
        repeat (2) tick();

        // Odd geometry, held start -> back-to-back passes.
        for (int e = 0; e < NI2; e++) in_m[2][e] = 16'($urandom);
        set_start(2, 1'b1);
        edges = 0;
        while (dq.size() < 3 && edges < 100) begin
            tick();
            edges++;
            if (done2) dq.push_back(edges);
        end
        set_start(2, 1'b0);
        check_val("odd_done_count", 32'(dq.size()), 32'd3);
        check_val("odd_first_done", 32'((dq.size() > 0) ? dq[0] : -1), 32'd9);
        check_val("odd_gap1", 32'((dq.size() > 1) ? dq[1] - dq[0] : -1), 32'd9);
        check_val("odd_gap2", 32'((dq.size() > 2) ? dq[2] - dq[1] : -1), 32'd9);
        repeat (3) tick();
        check_val("odd_idle_busy", 32'(busy2), 32'd0);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
